// File: rtl/uart_receiver_fsm.sv
// Purpose : 8N1 UART receiver, 16x oversampled, one-cycle valid/error strobes.
// Latency : rxd -> rxd_s is 2 clk_i; strobes appear the cycle after the mid-stop-bit tick.
// Backpr. : none; data is overwritten by the next good frame (consumer must take it on rx_valid).
//
// Ports:
//   clk_i     system clock
//   rstb_i    asynchronous active-low reset
//   rxd       serial input, asynchronous to clk_i, idle high
//   baud_x16  single-cycle enable, OVERSAMPLE pulses per bit period
//   data      last correctly received byte
//   rx_valid  one-cycle pulse, data updated
//   frame_err one-cycle pulse, stop bit sampled low
//   busy      high whenever the FSM is not idle
module uart_receiver_fsm #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rstb_i,
  input  logic                 rxd,
  input  logic                 baud_x16,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                state_q, state_nxt;
  logic                  rxd_meta, rxd_s;
  logic [CW-1:0]         cnt_q, cnt_nxt;
  logic [IW-1:0]         idx_q, idx_nxt;
  logic [DATA_BITS-1:0]  shift_q, shift_nxt;
  logic [DATA_BITS-1:0]  data_q;
  logic                  rx_valid_q, frame_err_q;
  logic                  good_stop, bad_stop;

  // State register plus datapath registers
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      rxd_meta    <= 1'b1;
      rxd_s       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rxd_meta    <= rxd;
      rxd_s       <= rxd_meta;
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      idx_q       <= idx_nxt;
      shift_q     <= shift_nxt;
      rx_valid_q  <= good_stop;
      frame_err_q <= bad_stop;
      if (good_stop) begin
        data_q <= shift_q;
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    shift_nxt = shift_q;
    cnt_nxt   = baud_x16 ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      S_IDLE: begin
        // Start edge is acted on immediately, not on a tick
        if (!rxd_s) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (baud_x16 && cnt_q == CNT_HALF) begin
          cnt_nxt = '0;
          if (!rxd_s) begin
            state_nxt = S_DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = S_IDLE;   // start bit did not hold: glitch
          end
        end
      end
      S_DATA: begin
        // Counter is aligned to mid-bit after the half-bit start wait
        if (baud_x16 && cnt_q == CNT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rxd_s, shift_q[DATA_BITS-1:1]};
          idx_nxt   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be caught
        if (baud_x16 && cnt_q == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rxd_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // Line held low after a bad stop must not be taken as a new start
        if (rxd_s) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state_q != S_IDLE);
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    if (state_q == S_STOP && baud_x16 && cnt_q == CNT_LAST) begin
      good_stop = rxd_s;
      bad_stop  = !rxd_s;
    end
  end

  assign data      = data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_receiver_fsm.sv
module tb_uart_receiver_fsm;

  logic       clk_i = 1'b0;
  logic       rstb_i;
  logic       rxd;
  logic       baud_x16;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int tick_per = 4;
  logic [7:0] exp_q[$];

  uart_receiver_fsm #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk_i    (clk_i),
    .rstb_i   (rstb_i),
    .rxd      (rxd),
    .baud_x16 (baud_x16),
    .data     (data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Baud tick generator: one pulse every tick_per clocks, or held high
  initial begin
    int div;
    div = 0;
    baud_x16 = 1'b0;
    forever begin
      @(negedge clk_i);
      if (tick_per == 1) begin
        baud_x16 = 1'b1;
      end else begin
        baud_x16 = (div == 0);
        div = (div + 1) % tick_per;
      end
    end
  end

  // Scoreboard: every rx_valid cycle pops one expected byte
  initial begin
    forever begin
      @(negedge clk_i);
      if (rx_valid) begin
        n_valid++;
        chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("rx_data", {24'd0, data}, {24'd0, e});
        end
      end
      if (frame_err) n_err++;
      if (rx_valid || frame_err) chk("strobe_excl", {31'd0, rx_valid && frame_err}, 32'd0);
    end
  end

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (16 * tick_per) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    logic [7:0] partial;
    rstb_i = 1'b0;
    rxd    = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("rst_data", {24'd0, data}, 32'h00);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rstb_i = 1'b1;
    idle(20);

    // 1: single good frame
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(64);
    chk("t1_nvalid", n_valid, 1);
    chk("t1_nerr", n_err, 0);
    chk("t1_data", {24'd0, data}, 32'hA5);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // 2: short start glitch
    rxd = 1'b0;
    repeat (4 * tick_per) @(negedge clk_i);
    chk("t2_busy_in_start", {31'd0, busy}, 32'd1);
    idle(200);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    chk("t2_nvalid", n_valid, 1);
    chk("t2_nerr", n_err, 0);
    chk("t2_data", {24'd0, data}, 32'hA5);

    // 3: bad stop bit, line held low, then released
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (40 * tick_per) @(negedge clk_i);
    chk("t3_nerr", n_err, 1);
    chk("t3_nvalid", n_valid, 1);
    chk("t3_data", {24'd0, data}, 32'hA5);
    chk("t3_busy_break", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("t3_busy_released", {31'd0, busy}, 32'd0);
    idle(64);

    // 4: back-to-back frames with no idle gap
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(64);
    chk("t4_nvalid", n_valid, 4);
    chk("t4_data", {24'd0, data}, 32'h81);

    // 5: reset after data bit 3 of 0x5A, then a good frame
    partial = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i]);
    rxd    = 1'b1;
    rstb_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_data", {24'd0, data}, 32'h00);
    rstb_i = 1'b1;
    idle(200);
    chk("t5_nvalid_abort", n_valid, 4);
    chk("t5_nerr_abort", n_err, 1);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(64);
    chk("t5_nvalid", n_valid, 5);
    chk("t5_data", {24'd0, data}, 32'hC3);

    // 6: baud_x16 held high, LSB-first ordering
    tick_per = 1;
    idle(20);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    exp_q.push_back(8'h80);
    send_frame(8'h80, 1'b1);
    idle(32);
    chk("t6_nvalid", n_valid, 7);
    chk("t6_data", {24'd0, data}, 32'h80);
    chk("t6_nerr", n_err, 1);
    chk("sb_drained", exp_q.size(), 0);
    chk("end_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
